vga_fb_arbiter: RTL

- Shares one single-port synchronous frame-buffer RAM between two users:
  - the VGA display fetch path, driven by pixel strobes from the display timing block;
  - a bus master (game/processor logic) that reads and writes pixels.
- Display fetches always win their issue edge. Bus accesses fill the remaining edges using a req/ack handshake.
- A tag pipeline returns each RAM read to the user that issued it.

---
 rtl/vga_fb_arbiter_if.sv | 51 +++++
 rtl/vga_fb_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Signal bundle for the frame-buffer arbiter.
// Covers the display fetch side, the bus master side and the single-port RAM side.
// The arbiter connects through the slave modport; the environment drives through master.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  // display fetch path
  logic              PIX_EN;
  logic              BLANK;
  logic [ADDR_W-1:0] VGA_ADDR;
  logic [DATA_W-1:0] VGA_DATA;
  logic              VGA_VALID;

  // bus master path
  logic              BUS_REQ;
  logic              BUS_WE;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [DATA_W-1:0] BUS_WDATA;
  logic [DATA_W-1:0] BUS_RDATA;
  logic              BUS_ACK;

  // frame-buffer RAM port
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;

  // statistics
  logic [15:0]       CONFLICTS;

  modport slave (
    input  PIX_EN, BLANK, VGA_ADDR,
    input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
    input  MEM_RDATA,
    output VGA_DATA, VGA_VALID,
    output BUS_RDATA, BUS_ACK,
    output MEM_ADDR, MEM_WE, MEM_WDATA,
    output CONFLICTS
  );

  modport master (
    output PIX_EN, BLANK, VGA_ADDR,
    output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
    output MEM_RDATA,
    input  VGA_DATA, VGA_VALID,
    input  BUS_RDATA, BUS_ACK,
    input  MEM_ADDR, MEM_WE, MEM_WDATA,
    input  CONFLICTS
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port synchronous RAM shared by the VGA
// display fetch (strict priority) and a req/ack bus master. A two-stage tag
// pipeline follows every RAM read so its data is delivered only to its owner.
module vga_fb_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 12,
  parameter int FB_DEPTH = 19200
) (
  input  logic            CLK,
  input  logic            RESET,
  vga_fb_arbiter_if.slave fb
);

  // one extra bit so a depth equal to 2**ADDR_W still fits
  localparam logic [ADDR_W:0] DEPTH = FB_DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WACK  = 2'd1,
    RWAIT = 2'd2,
    RRET  = 2'd3
  } bus_state_t;

  // disp_v   : a display slot (fetch or blanked strobe) is travelling
  // disp_live: that slot really read the RAM at an in-range address
  // bus_v    : a bus read is travelling
  // bus_inr  : that bus read address was in range
  typedef struct packed {
    logic disp_v;
    logic disp_live;
    logic bus_v;
    logic bus_inr;
  } tag_t;

  bus_state_t        state;
  bus_state_t        state_next;
  logic              ack_next;

  tag_t              tag_in;
  tag_t              tag0;
  tag_t              tag1;

  logic              vga_inr;
  logic              bus_inr;
  logic              disp_issue;
  logic              bus_issue;
  logic              bus_defer;

  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [15:0]       conflicts;

  // issue decode: display owns any unblanked strobe edge, bus takes the rest
  always_comb begin
    vga_inr    = ({1'b0, fb.VGA_ADDR} < DEPTH);
    bus_inr    = ({1'b0, fb.BUS_ADDR} < DEPTH);
    disp_issue = fb.PIX_EN & ~fb.BLANK;
    bus_issue  = (state == IDLE) & fb.BUS_REQ & ~disp_issue;
    bus_defer  = (state == IDLE) & fb.BUS_REQ & disp_issue;

    tag_in           = '0;
    tag_in.disp_v    = fb.PIX_EN;
    tag_in.disp_live = disp_issue & vga_inr;
    tag_in.bus_v     = bus_issue & ~fb.BUS_WE;
    tag_in.bus_inr   = bus_inr;
  end

  // bus FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // bus FSM next state and registered-ack request
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus_issue) state_next = fb.BUS_WE ? WACK : RWAIT;
      end
      WACK: begin
        ack_next   = 1'b1;
        state_next = IDLE;
      end
      RWAIT: begin
        state_next = RRET;
      end
      RRET: begin
        ack_next   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // tag pipeline: stage 1 lines up with MEM_RDATA of the read issued two edges ago
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tag0 <= '0;
      tag1 <= '0;
    end else begin
      tag0 <= tag_in;
      tag1 <= tag0;
    end
  end

  // display return: blanked or out-of-range slots deliver zero at the same latency
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vga_valid <= 1'b0;
      vga_data  <= '0;
    end else begin
      vga_valid <= tag1.disp_v;
      if (tag1.disp_v) vga_data <= tag1.disp_live ? fb.MEM_RDATA : '0;
    end
  end

  // bus return: read data only from a bus-owned tag, ack pulse from the FSM
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack <= ack_next;
      if (state == RRET && tag1.bus_v) bus_rdata <= tag1.bus_inr ? fb.MEM_RDATA : '0;
    end
  end

  // RAM port registers: at most one issue per edge, write enable is a single pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (disp_issue) begin
      mem_addr  <= fb.VGA_ADDR;
      mem_we    <= 1'b0;
    end else if (bus_issue) begin
      mem_addr  <= fb.BUS_ADDR;
      mem_we    <= fb.BUS_WE & bus_inr;
      mem_wdata <= fb.BUS_WDATA;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // saturating count of bus issues pushed back by a display fetch
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                         conflicts <= '0;
    else if (bus_defer && conflicts != '1) conflicts <= conflicts + 16'd1;
  end

  assign fb.VGA_DATA  = vga_data;
  assign fb.VGA_VALID = vga_valid;
  assign fb.BUS_RDATA = bus_rdata;
  assign fb.BUS_ACK   = bus_ack;
  assign fb.MEM_ADDR  = mem_addr;
  assign fb.MEM_WE    = mem_we;
  assign fb.MEM_WDATA = mem_wdata;
  assign fb.CONFLICTS = conflicts;

endmodule
